mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_addsub.sv | 20 ++
 rtl/mul_div_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the RV32M multiply/divide unit:
//   default operand width, funct3 operation encodings, FSM state encoding
//   and helpers deciding which operands are treated as signed.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } state_t;

  // rs1 is signed for every op except the fully unsigned ones. MUL is treated
  // as signed; its low half does not depend on signedness anyway.
  function automatic logic a_is_signed(funct3_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is unsigned for MULHSU in addition to the unsigned ops.
  function automatic logic b_is_signed(funct3_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub
//   XLEN+1-bit adder/subtractor shared by the shift-add multiplier and the
//   restoring divider. One carry chain serves both iteration kinds.
// Ports:
//   a, b  : XLEN+1-bit operands
//   sub   : 0 -> sum = a + b, 1 -> sum = a - b (two's complement)
//   sum   : XLEN+1-bit result, carry out of the top bit discarded
module muldiv_addsub #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0] a,
  input  logic [XLEN:0] b,
  input  logic          sub,
  output logic [XLEN:0] sum
);

  // Subtraction as a + ~b + 1 so a single adder covers both modes.
  assign sum = a + (b ^ {(XLEN + 1){sub}}) + {{XLEN{1'b0}}, sub};

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative RV32M multiply/divide unit with fixed latency of XLEN+2 cycles
//   from the start edge to the done pulse. Multiplication is shift-add over a
//   2*XLEN product register; division is restoring, one quotient bit per cycle.
//   Operands are converted to magnitudes in PREP and the sign is restored in FIN.
// Configuration:
//   MUL_DIV_UNIT_DIV_EN - when defined, DIV/DIVU/REM/REMU are supported. When
//   undefined the divider is left out and any op with funct3[2]=1 is answered
//   one cycle later with done and illegal pulsed and result cleared to 0.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   start   : request an operation, sampled only in IDLE
//   funct3  : RV32M operation select
//   op_a    : rs1 value
//   op_b    : rs2 value
//   busy    : high while an operation is in progress
//   done    : one-cycle pulse, result valid in that cycle
//   result  : last completed result, held until the next done
//   illegal : one-cycle pulse alongside done for an unsupported op
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN);

  state_t            state, state_next;
  funct3_t           op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] prod;
  logic [CW-1:0]     cnt;
  logic              neg_res;

  logic              unsupported;
  logic              done_next, illegal_next, load_result;
  logic [XLEN-1:0]   result_next;

  logic              sign_a, sign_b, neg_prep;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   prep_operand, prep_lo;
  logic [XLEN-1:0]   hi, lo;
  logic [2*XLEN-1:0] prod_step, prod_signed;
  logic [XLEN-1:0]   fin_result;

  logic [XLEN:0]     add_a, add_b, add_sum;
  logic              add_sub;

  assign hi   = prod[2*XLEN-1:XLEN];
  assign lo   = prod[XLEN-1:0];
  assign busy = (state != IDLE);

`ifdef MUL_DIV_UNIT_DIV_EN
  assign unsupported = 1'b0;
`else
  assign unsupported = funct3[2];
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output-pulse decode. An unsupported op never leaves IDLE,
  // so busy stays low while done/illegal pulse for one cycle.
  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    load_result  = 1'b0;
    result_next  = '0;
    case (state)
      IDLE: begin
        if (start && unsupported) begin
          done_next    = 1'b1;
          illegal_next = 1'b1;
          load_result  = 1'b1;
        end else if (start) begin
          state_next = PREP;
        end
      end
      PREP: state_next = CALC;
      CALC: begin
        if (cnt == CW'(XLEN - 1)) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next  = IDLE;
        done_next   = 1'b1;
        load_result = 1'b1;
        result_next = fin_result;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand magnitudes and the sign the final result must carry.
  assign sign_a = a_is_signed(op_q) & a_q[XLEN-1];
  assign sign_b = b_is_signed(op_q) & b_q[XLEN-1];
  assign mag_a  = sign_a ? -a_q : a_q;
  assign mag_b  = sign_b ? -b_q : b_q;

  // Divide-by-zero must return all-ones for a signed quotient too, so the
  // quotient sign is suppressed when the divisor is zero. The remainder
  // follows the dividend, which also makes REM by zero return op_a.
  always_comb begin
    neg_prep = sign_a ^ sign_b;
`ifdef MUL_DIV_UNIT_DIV_EN
    if (op_q[2]) begin
      neg_prep = op_q[1] ? sign_a : ((sign_a ^ sign_b) & (b_q != '0));
    end
`endif
  end

  // Adder inputs: accumulate the multiplicand into the high half, or try
  // subtracting the divisor from the shifted partial remainder.
  always_comb begin
    add_a   = {1'b0, hi};
    add_b   = {1'b0, operand};
    add_sub = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
    if (op_q[2]) begin
      add_a   = {hi, lo[XLEN-1]};
      add_sub = 1'b1;
    end
`endif
  end

  muldiv_addsub #(.XLEN(XLEN)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  // One iteration of the product/remainder register. For division the high
  // half is the partial remainder and the low half shifts dividend bits out
  // while quotient bits shift in. Because the remainder stays below the
  // divisor, bit XLEN of the difference is a reliable borrow flag.
  always_comb begin
    prep_operand = mag_a;
    prep_lo      = mag_b;
    prod_step    = lo[0] ? {add_sum, lo[XLEN-1:1]} : {1'b0, hi, lo[XLEN-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
    if (op_q[2]) begin
      prep_operand = mag_b;
      prep_lo      = mag_a;
      prod_step    = add_sum[XLEN] ? {hi[XLEN-2:0], lo[XLEN-1], lo[XLEN-2:0], 1'b0}
                                   : {add_sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    end
`endif
  end

  // Sign correction of the magnitude result for the selected half.
  always_comb begin
    prod_signed = neg_res ? -prod : prod;
    fin_result  = (op_q == OP_MUL) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
`ifdef MUL_DIV_UNIT_DIV_EN
    if (op_q[2]) begin
      fin_result = op_q[1] ? (neg_res ? -hi : hi) : (neg_res ? -lo : lo);
    end
`endif
  end

  // Datapath registers: operand capture on the accepting edge, magnitude
  // setup in PREP and one shift step per CALC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      operand <= '0;
      prod    <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (state_next == PREP) begin
            op_q <= funct3_t'(funct3);
            a_q  <= op_a;
            b_q  <= op_b;
          end
        end
        PREP: begin
          operand <= prep_operand;
          prod    <= {{XLEN{1'b0}}, prep_lo};
          cnt     <= '0;
          neg_res <= neg_prep;
        end
        CALC: begin
          prod <= prod_step;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; result only changes when a done pulse is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done    <= 1'b0;
      illegal <= 1'b0;
      result  <= '0;
    end else begin
      done    <= done_next;
      illegal <= illegal_next;
      if (load_result) begin
        result <= result_next;
      end
    end
  end

endmodule
